// File: rtl/layer_lp_seq_pkg.sv
// Shared types for the layer_lp sequencer: FSM state encoding, issue tag
// carried down the read-latency delay line, and a width helper.
package layer_lp_seq_pkg;

  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic valid;
    logic last_chunk;
  } issue_tag_t;

  localparam int TAG_W = $bits(issue_tag_t);

  // Bits needed to hold 'value'; never below 1 so single-layer builds keep a
  // real layer_id port.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_delay_line.sv
// RD_LAT-deep shift register of issue tags; re-times each issue so en and
// acc_clear_and_go line up with the weight data. flush_i empties all stages.
module seq_delay_line
  import layer_lp_seq_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o
);

  issue_tag_t [RD_LAT-1:0] pipe_q;

  // Shift tags one stage per cycle; flush drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else if (flush_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/layer_lp_sequencer.sv
// Sequences one layer_lp datapath through a multi-layer inference: weight and
// spike read addresses, conv enable/clear strobes and layer_id.
// Optional macro SEQ_PERF_CNT_EN adds a saturating busy-cycle counter.
module layer_lp_sequencer
  import layer_lp_seq_pkg::*;
#(
  parameter int LAYERS       = 4,
  parameter int WEIGHT_DEPTH = 8192,
  parameter int MAX_NEURON   = 256,
  parameter int MAX_CHUNK    = 64,
  parameter int RD_LAT       = RD_LAT_DEF,
  parameter int DRAIN        = 8,
  localparam int ADDR_W      = clogb2(WEIGHT_DEPTH - 1),
  localparam int NW          = clogb2(MAX_NEURON),
  localparam int CW          = clogb2(MAX_CHUNK),
  localparam int LW          = clogb2(LAYERS - 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LAYERS*NW-1:0] cfg_neurons_i,
  input  logic [LAYERS*CW-1:0] cfg_chunks_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_error_o,
  output logic [ADDR_W-1:0]    weight_rd_addr_o,
  output logic [CW-1:0]        spike_rd_addr_o,
  output logic                 spike_bank_o,
  output logic                 en_o,
  output logic                 acc_clear_o,
  output logic                 acc_clear_and_go_o,
  output logic [LW-1:0]        layer_id_o,
  output logic [31:0]          cycle_count_o
);

  localparam int DRW = clogb2(RD_LAT + DRAIN - 1);

  seq_state_t           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 full_q, full_d;   // address WEIGHT_DEPTH-1 already issued
  logic [CW-1:0]        chunk_q, chunk_d;
  logic [NW-1:0]        neuron_q, neuron_d;
  logic [LW-1:0]        layer_q, layer_d;
  logic [DRW-1:0]       drain_q, drain_d;
  logic [LAYERS*NW-1:0] ncfg_q, ncfg_d;
  logic [LAYERS*CW-1:0] ccfg_q, ccfg_d;
  logic                 err_q, err_d;

  issue_tag_t tag_in, tag_out;
  logic       flush;
  logic       last_chunk, last_neuron;

  assign last_chunk  = (chunk_q  == ccfg_q[layer_q*CW +: CW]);
  assign last_neuron = (neuron_q == ncfg_q[layer_q*NW +: NW]);

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      full_q   <= 1'b0;
      chunk_q  <= '0;
      neuron_q <= '0;
      layer_q  <= '0;
      drain_q  <= '0;
      ncfg_q   <= '0;
      ccfg_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      full_q   <= full_d;
      chunk_q  <= chunk_d;
      neuron_q <= neuron_d;
      layer_q  <= layer_d;
      drain_q  <= drain_d;
      ncfg_q   <= ncfg_d;
      ccfg_q   <= ccfg_d;
      err_q    <= err_d;
    end
  end

  // Next state, issue walk and address overflow handling.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    full_d   = full_q;
    chunk_d  = chunk_q;
    neuron_d = neuron_q;
    layer_d  = layer_q;
    drain_d  = drain_q;
    ncfg_d   = ncfg_q;
    ccfg_d   = ccfg_q;
    err_d    = err_q;
    tag_in   = '0;
    flush    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        state_d  = S_CLEAR;
        ncfg_d   = cfg_neurons_i;
        ccfg_d   = cfg_chunks_i;
        err_d    = 1'b0;
        addr_d   = '0;
        full_d   = 1'b0;
        chunk_d  = '0;
        neuron_d = '0;
        layer_d  = '0;
      end
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: begin
        if (full_q) begin
          // Next issue would need address WEIGHT_DEPTH: abort without wrapping.
          err_d   = 1'b1;
          flush   = 1'b1;
          state_d = S_DONE;
        end else begin
          tag_in.valid      = 1'b1;
          tag_in.last_chunk = last_chunk;
          if (addr_q == ADDR_W'(WEIGHT_DEPTH - 1)) full_d = 1'b1;
          else                                     addr_d = addr_q + 1'b1;
          if (last_chunk) begin
            chunk_d  = '0;
            neuron_d = neuron_q + 1'b1;
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
          if (last_chunk && last_neuron) begin
            neuron_d = '0;
            drain_d  = '0;
            state_d  = S_DRAIN;
          end
        end
      end
      // RD_LAT cycles empty the delay line, then DRAIN quiet cycles follow,
      // so layer_id only moves once no strobe can still be in flight.
      S_DRAIN: begin
        if (drain_q == DRW'(RD_LAT + DRAIN - 1)) begin
          if (layer_q == LW'(LAYERS - 1)) begin
            state_d = S_DONE;
          end else begin
            layer_d  = layer_q + 1'b1;
            chunk_d  = '0;
            neuron_d = '0;
            state_d  = S_CLEAR;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    acc_clear_o = 1'b0;
    unique case (state_q)
      S_CLEAR: begin busy_o = 1'b1; acc_clear_o = 1'b1; end
      S_ISSUE: busy_o = 1'b1;
      S_DRAIN: busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  seq_delay_line #(.RD_LAT(RD_LAT)) u_dly (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  assign en_o               = tag_out.valid;
  assign acc_clear_and_go_o = tag_out.valid & tag_out.last_chunk;
  assign weight_rd_addr_o   = addr_q;
  assign spike_rd_addr_o    = chunk_q;
  assign layer_id_o         = layer_q;
  assign spike_bank_o       = layer_q[0];
  assign cfg_error_o        = err_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_q;

  // Counts every non-idle cycle of a run, saturating; held until next start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 cyc_q <= '0;
    else if (state_q == S_IDLE) begin
      if (start_i)               cyc_q <= '0;
    end else if (cyc_q != '1)    cyc_q <= cyc_q + 1'b1;
  end

  assign cycle_count_o = cyc_q;
`else
  assign cycle_count_o = '0;
`endif

endmodule

// File: tb/tb_layer_lp_sequencer.sv
// Directed bench for layer_lp_sequencer: three instances cover a single layer,
// a two-layer run and a 16-entry weight memory overflow.
module tb_layer_lp_sequencer;
  import layer_lp_seq_pkg::*;

  localparam int NW = clogb2(256);
  localparam int CW = clogb2(64);

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // instance a: LAYERS=1, default depth
  logic          start_a;
  logic [NW-1:0] neur_a;
  logic [CW-1:0] chunk_a;
  logic          busy_a, done_a, err_a, bank_a, en_a, clr_a, go_a;
  logic [12:0]   addr_a;
  logic [CW-1:0] spk_a;
  logic [0:0]    lid_a;
  logic [31:0]   cyc_a;

  // instance b: LAYERS=2
  logic            start_b;
  logic [2*NW-1:0] neur_b;
  logic [2*CW-1:0] chunk_b;
  logic            busy_b, done_b, err_b, bank_b, en_b, clr_b, go_b;
  logic [12:0]     addr_b;
  logic [CW-1:0]   spk_b;
  logic [0:0]      lid_b;
  logic [31:0]     cyc_b;

  // instance c: LAYERS=1, WEIGHT_DEPTH=16
  logic          start_c;
  logic [NW-1:0] neur_c;
  logic [CW-1:0] chunk_c;
  logic          busy_c, done_c, err_c, bank_c, en_c, clr_c, go_c;
  logic [3:0]    addr_c;
  logic [CW-1:0] spk_c;
  logic [0:0]    lid_c;
  logic [31:0]   cyc_c;

  layer_lp_sequencer #(.LAYERS(1)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_a),
    .cfg_neurons_i(neur_a), .cfg_chunks_i(chunk_a),
    .busy_o(busy_a), .done_o(done_a), .cfg_error_o(err_a),
    .weight_rd_addr_o(addr_a), .spike_rd_addr_o(spk_a), .spike_bank_o(bank_a),
    .en_o(en_a), .acc_clear_o(clr_a), .acc_clear_and_go_o(go_a),
    .layer_id_o(lid_a), .cycle_count_o(cyc_a));

  layer_lp_sequencer #(.LAYERS(2)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_b),
    .cfg_neurons_i(neur_b), .cfg_chunks_i(chunk_b),
    .busy_o(busy_b), .done_o(done_b), .cfg_error_o(err_b),
    .weight_rd_addr_o(addr_b), .spike_rd_addr_o(spk_b), .spike_bank_o(bank_b),
    .en_o(en_b), .acc_clear_o(clr_b), .acc_clear_and_go_o(go_b),
    .layer_id_o(lid_b), .cycle_count_o(cyc_b));

  layer_lp_sequencer #(.LAYERS(1), .WEIGHT_DEPTH(16)) u_dut_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_c),
    .cfg_neurons_i(neur_c), .cfg_chunks_i(chunk_c),
    .busy_o(busy_c), .done_o(done_c), .cfg_error_o(err_c),
    .weight_rd_addr_o(addr_c), .spike_rd_addr_o(spk_c), .spike_bank_o(bank_c),
    .en_o(en_c), .acc_clear_o(clr_c), .acc_clear_and_go_o(go_c),
    .layer_id_o(lid_c), .cycle_count_o(cyc_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // 2 neurons x 3 chunks on instance a; k=0 is the CLEAR cycle.
  // Stray start pulses at k=4 (ISSUE) and k=17 (DONE) must be ignored.
  task automatic run_a_basic(input string t);
    neur_a  = NW'(1);
    chunk_a = CW'(2);
    start_a = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("%s.en@%0d", t, k),   en_a,   (k >= 3 && k <= 8));
      chk($sformatf("%s.go@%0d", t, k),   go_a,   (k == 5 || k == 8));
      chk($sformatf("%s.clr@%0d", t, k),  clr_a,  (k == 0));
      chk($sformatf("%s.busy@%0d", t, k), busy_a, (k <= 16));
      chk($sformatf("%s.done@%0d", t, k), done_a, (k == 17));
      if (k >= 1 && k <= 6) begin
        chk($sformatf("%s.addr@%0d", t, k), addr_a, k - 1);
        chk($sformatf("%s.spk@%0d", t, k),  spk_a,  (k - 1) % 3);
      end
      if (k >= 18) begin
`ifdef SEQ_PERF_CNT_EN
        chk($sformatf("%s.cyc@%0d", t, k), cyc_a, 18);
`else
        chk($sformatf("%s.cyc@%0d", t, k), cyc_a, 0);
`endif
      end
      start_a = (k == 4 || k == 17);
      tick();
    end
    start_a = 1'b0;
  endtask

  initial begin
    start_a = 0; start_b = 0; start_c = 0;
    neur_a = '0; chunk_a = '0; neur_b = '0; chunk_b = '0; neur_c = '0; chunk_c = '0;
    #1 rst_ni = 1'b0;
    #2;
    chk("rst.busy", busy_a, 0);
    chk("rst.done", done_a, 0);
    chk("rst.en",   en_a,   0);
    chk("rst.go",   go_a,   0);
    chk("rst.clr",  clr_a,  0);
    chk("rst.addr", addr_a, 0);
    chk("rst.err",  err_a,  0);
    chk("rst.lid",  lid_b,  0);
    chk("rst.cyc",  cyc_a,  0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // single layer, 2 neurons x 3 chunks
    run_a_basic("t1");

    // cfg_chunks=0, 4 neurons: go on every en cycle
    neur_a = NW'(3); chunk_a = CW'(0); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("t3.en@%0d", k),   en_a,   (k >= 3 && k <= 6));
      chk($sformatf("t3.go@%0d", k),   go_a,   (k >= 3 && k <= 6));
      chk($sformatf("t3.done@%0d", k), done_a, (k == 15));
      if (k >= 1 && k <= 4) chk($sformatf("t3.addr@%0d", k), addr_a, k - 1);
      tick();
    end

    // two layers: 2x1 then 1x3, addresses continue 2..4 in layer 1
    neur_b  = {NW'(0), NW'(1)};
    chunk_b = {CW'(2), CW'(0)};
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("t2.en@%0d", k),   en_b,  ((k >= 3 && k <= 4) || (k >= 16 && k <= 18)));
      chk($sformatf("t2.go@%0d", k),   go_b,  (k == 3 || k == 4 || k == 18));
      chk($sformatf("t2.clr@%0d", k),  clr_b, (k == 0 || k == 13));
      chk($sformatf("t2.done@%0d", k), done_b, (k == 27));
      if (k <= 27) begin
        chk($sformatf("t2.lid@%0d", k),  lid_b,  (k >= 13));
        chk($sformatf("t2.bank@%0d", k), bank_b, (k >= 13));
      end
      if (k >= 1 && k <= 2)   chk($sformatf("t2.addr@%0d", k), addr_b, k - 1);
      if (k >= 14 && k <= 16) begin
        chk($sformatf("t2.addr@%0d", k), addr_b, k - 12);
        chk($sformatf("t2.spk@%0d", k),  spk_b,  k - 14);
      end
      tick();
    end

    // 16-entry weight memory, 5 neurons x 4 chunks = 20 issues: overflow
    neur_c = NW'(4); chunk_c = CW'(3); start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int k = 0; k < 21; k++) begin
      chk($sformatf("t4.en@%0d", k),   en_c,   (k >= 3 && k <= 17));
      chk($sformatf("t4.go@%0d", k),   go_c,   (k == 6 || k == 10 || k == 14));
      chk($sformatf("t4.done@%0d", k), done_c, (k == 18));
      chk($sformatf("t4.err@%0d", k),  err_c,  (k >= 18));
      chk($sformatf("t4.busy@%0d", k), busy_c, (k <= 17));
      if (k >= 1 && k <= 16) chk($sformatf("t4.addr@%0d", k), addr_c, k - 1);
      if (k == 17)           chk("t4.addr_hold", addr_c, 15);
      tick();
    end
    // restart clears cfg_error and begins again at address 0
    neur_c = NW'(0); chunk_c = CW'(0); start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("t4r.err@%0d", k),  err_c,  0);
      chk($sformatf("t4r.en@%0d", k),   en_c,   (k == 3));
      chk($sformatf("t4r.go@%0d", k),   go_c,   (k == 3));
      chk($sformatf("t4r.done@%0d", k), done_c, (k == 12));
      if (k == 1) chk("t4r.addr", addr_c, 0);
      tick();
    end

    // reset in the middle of ISSUE aborts with no done pulse
    neur_a = NW'(1); chunk_a = CW'(2); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick();
    chk("t5.en_pre", en_a, 1);
    rst_ni = 1'b0;
    #1;
    chk("t5.en",   en_a,   0);
    chk("t5.go",   go_a,   0);
    chk("t5.busy", busy_a, 0);
    chk("t5.addr", addr_a, 0);
    chk("t5.spk",  spk_a,  0);
    chk("t5.clr",  clr_a,  0);
    tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t5.done@%0d", k), done_a, 0);
      chk($sformatf("t5.idle@%0d", k), busy_a, 0);
      tick();
    end
    run_a_basic("t5r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_lp_sequencer.md
Name: layer_lp_sequencer

Overview:
- Drives one layer_lp datapath through a full multi-layer inference.
- Generates the weight-memory read address, the spike-buffer read address, conv enable and clear strobes, and layer_id.
- Accounts for the 2-cycle HIGH_PERFORMANCE weight-read latency.
- Sits between the top-level inference FSM (start/done) and layer_lp; the spike buffer is external.

Parameters:
- LAYERS, 4, number of layers sequenced (1..4).
- WEIGHT_DEPTH, 8192, weight memory depth; ADDR_W = clogb2(WEIGHT_DEPTH-1).
- MAX_NEURON, 256, maximum neurons per layer; NW = clogb2(MAX_NEURON).
- MAX_CHUNK, 64, maximum 4-spike input chunks per neuron; CW = clogb2(MAX_CHUNK).
- RD_LAT, 2, weight/spike read latency in cycles.
- DRAIN, 8, idle cycles after a layer's last acc_clear_and_go before layer_id changes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins an inference when idle.
- cfg_neurons  in  LAYERS*NW  per-layer neuron count minus 1 (layer k at [k*NW+:NW]).
- cfg_chunks  in  LAYERS*CW  per-layer chunks-per-neuron minus 1.
- busy  out  1  high from the start acceptance until done.
- done  out  1  one-cycle pulse at the end of the inference.
- cfg_error  out  1  sticky flag: weight address would exceed WEIGHT_DEPTH-1.
- weight_rd_addr  out  ADDR_W  to layer_lp.
- spike_rd_addr  out  CW  chunk index to the spike buffer.
- spike_bank  out  1  ping-pong bank select = layer_id[0].
- en  out  1  conv enable, aligned with weight data.
- acc_clear  out  1  conv accumulator clear.
- acc_clear_and_go  out  1  conv push to neuron, aligned with the last chunk of each neuron.
- layer_id  out  clogb2(LAYERS-1)  to layer_lp.
- cycle_count  out  32  see Optional Feature.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; address and neuron/chunk counters 0; cfg_error 0.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → latch cfg_neurons/cfg_chunks, clear cfg_error, set busy=1, go to CLEAR.
  - start is ignored when not in IDLE.
- CLEAR (1 cycle): acc_clear=1, layer_id set to the current layer, go to ISSUE.
- ISSUE (one issue per cycle, no bubbles):
  - Present weight_rd_addr = running address and spike_rd_addr = chunk.
  - Per cycle: chunk increments; at cfg_chunks it wraps to 0 and neuron increments.
  - At the last chunk of the last neuron, go to DRAIN.
  - Issue tags are {valid, last_chunk}, delayed RD_LAT cycles: en = delayed valid; acc_clear_and_go = delayed (valid & last_chunk).
- Address rule:
  - Running address starts at 0 on start and increments every issue, continuing across layers (weights are contiguous layer-major, neuron-major, chunk-minor).
  - If an issue would need address WEIGHT_DEPTH: set cfg_error, stop issuing, flush the delay line, go to DONE. It never wraps.
- DRAIN:
  - Wait RD_LAT cycles for the delay line to empty, then DRAIN cycles.
  - Then, if layer_id == LAYERS-1, go to DONE; else increment layer_id, reset neuron/chunk, go to CLEAR.
  - layer_id never changes while en or acc_clear_and_go can still be asserted.
- DONE (1 cycle): done=1, busy=0, go to IDLE. weight_rd_addr holds its last value.
- Boundary cases:
  - cfg_chunks=0 → every issue is a last chunk; acc_clear_and_go pulses every cycle.
  - cfg_neurons=0 → one neuron in that layer.
  - start coincident with DONE is ignored.
  - Reset mid-run aborts immediately; no done pulse.

Optional Feature:
- SEQ_PERF_CNT_EN defined:
  - cycle_count clears on start acceptance and increments every busy cycle, saturating at 2^32-1.
  - Holds its value after done until the next start.
- Undefined: cycle_count tied to 0 and no counter logic is generated.

Decomposition:
- Package layer_lp_seq_pkg:
  - state enum seq_state_t.
  - RD_LAT default.
  - issue tag struct {valid, last_chunk}.
- One sub-module, seq_delay_line: parameterised RD_LAT-deep shift register of issue tags, with async active-low reset and a flush input.

Test Plan:
- LAYERS=1, cfg_neurons=1, cfg_chunks=2, start → addr 0..5 on consecutive cycles; en high 6 cycles starting 2 cycles after the first issue; acc_clear_and_go on the 3rd and 6th en cycles; done after RD_LAT+DRAIN.
- LAYERS=2, layer0 = 2 neurons × 1 chunk, layer1 = 1 neuron × 3 chunks → layer1 addresses 2..4; layer_id changes only after DRAIN; acc_clear pulses twice; spike_bank toggles.
- cfg_chunks=0, 4 neurons → acc_clear_and_go high on 4 consecutive cycles coincident with en.
- WEIGHT_DEPTH=16, 1 layer × 5 neurons × 4 chunks → cfg_error set at address 15→16 attempt; no address ≥16 issued; done pulses.
- rst low mid-ISSUE → all outputs 0 immediately; a subsequent start runs cleanly from address 0.
- SEQ_PERF_CNT_EN defined, first test → cycle_count = number of busy cycles (1+6+RD_LAT+DRAIN+1); start during busy is ignored.
